tff_updown_counter: RTL

- Synchronous modulo-N up/down counter built from toggle-flop stages.
- Each stage's T input is computed from the lower bits, the direction and the wrap condition.
- Sits directly upstream of banks of T flip-flops. It generates and exports the per-bit toggle vector, so downstream toggle stages can mirror the count or chain to it.
- Replaces the X-on-start workaround with a defined asynchronous reset.

---
 rtl/tff_updown_counter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tff_updown_counter.sv
// ---------------------------------------------------------------------------
// tff_updown_counter
//
// Synchronous modulo-MODULUS up/down counter built as a bank of toggle
// stages. Each edge computes a toggle vector T from the lower bits, the count
// direction and the wrap condition, then forms the next count as q ^ T. The
// same T vector is registered and exported on t_out so that downstream
// T flip-flop banks can mirror this count or chain from it.
//
// Parameters
//   WIDTH    counter / toggle vector width in bits (2..16)
//   MODULUS  count sequence length, 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   en        in   1      count enable, ignored while load=1
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      synchronous load request, has priority over en
//   load_val  in   WIDTH  value to load
//   clr_err   in   1      synchronous clear of the err flag
//   q         out  WIDTH  current count
//   t_out     out  WIDTH  toggle vector applied at the last edge
//   tc        out  1      one-cycle terminal-count pulse on wrap
//   err       out  1      sticky flag: out-of-range load seen
// ---------------------------------------------------------------------------
module tff_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_out,
  output logic             tc,
  output logic             err
);

  // MODULUS may equal 2**WIDTH, so range checks are done one bit wider.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_down;
  logic [WIDTH-1:0] t_next;
  logic [WIDTH-1:0] load_target;
  logic             load_ok;
  logic             q_oor;
  logic             tc_next;
  logic             err_next;

  // Ripple-free toggle terms for the non-wrap cases: counting up, bit i
  // flips when every lower bit is 1; counting down, when every lower bit
  // is 0. Bit 0 always flips.
  for (genvar i = 0; i < WIDTH; i++) begin : g_toggle
    if (i == 0) begin : g_lsb
      assign t_up[i]   = 1'b1;
      assign t_down[i] = 1'b1;
    end else begin : g_upper
      assign t_up[i]   = &q[i-1:0];
      assign t_down[i] = ~|q[i-1:0];
    end
  end

  // Out-of-range loads clamp to the top of the sequence.
  assign load_ok     = {1'b0, load_val} < MOD_EXT;
  assign load_target = load_ok ? load_val : TOP;

  // Only reachable if the state is somehow disturbed; a count edge from
  // such a value returns to 0 without a terminal-count pulse.
  assign q_oor = {1'b0, q} >= MOD_EXT;

  // Toggle vector and terminal count for this edge. A wrap is expressed as
  // q XOR target so that every path still updates q purely by toggling.
  always_comb begin
    t_next  = '0;
    tc_next = 1'b0;
    if (load) begin
      t_next = q ^ load_target;
    end else if (en) begin
      if (q_oor) begin
        t_next = q;
      end else if (up) begin
        if (q == TOP) begin
          t_next  = q;
          tc_next = 1'b1;
        end else begin
          t_next = t_up;
        end
      end else begin
        if (q == '0) begin
          t_next  = q ^ TOP;
          tc_next = 1'b1;
        end else begin
          t_next = t_down;
        end
      end
    end
  end

  // A bad load in the same cycle as clr_err leaves the flag set.
  always_comb begin
    err_next = err;
    if (load && !load_ok) begin
      err_next = 1'b1;
    end else if (clr_err) begin
      err_next = 1'b0;
    end
  end

  // Registered outputs; t_out reports the vector applied at this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      t_out <= '0;
      tc    <= 1'b0;
      err   <= 1'b0;
    end else begin
      q     <= q ^ t_next;
      t_out <= t_next;
      tc    <= tc_next;
      err   <= err_next;
    end
  end

endmodule
